// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch timing/mode controller: prescalers, RUN/PAUSED/ADJ state machine,
// and single-cycle clock-enable strobes for the counter and display datapath.
module stopwatch_tick_ctrl #(
   parameter int unsigned DIV_1HZ   = 100000000,
   parameter int unsigned DIV_2HZ   = 50000000,
   parameter int unsigned DIV_BLINK = 25000000,
   parameter int unsigned DIV_SCAN  = 200000,
   parameter int unsigned CNT_W     = 27
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       pause_p,
   input  logic       clear_p,
   input  logic       adj,
   input  logic       sel,
   output logic       inc_sec,
   output logic       inc_min_adj,
   output logic       inc_sec_adj,
   output logic       clear_cnt,
   output logic       blink_on,
   output logic       field_sel,
   output logic       scan_tick,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      PAUSED = 2'b01,
      ADJ    = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] TOP_1HZ   = CNT_W'(DIV_1HZ - 1);
   localparam logic [CNT_W-1:0] TOP_2HZ   = CNT_W'(DIV_2HZ - 1);
   localparam logic [CNT_W-1:0] TOP_BLINK = CNT_W'(DIV_BLINK - 1);
   localparam logic [CNT_W-1:0] TOP_SCAN  = CNT_W'(DIV_SCAN - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state;
   state_t           ret_state;
   logic [CNT_W-1:0] cnt_1hz;
   logic [CNT_W-1:0] cnt_2hz;
   logic [CNT_W-1:0] cnt_blink;
   logic [CNT_W-1:0] cnt_scan;
   logic             wrap_1hz;
   logic             wrap_2hz;
   logic             wrap_blink;
   logic             wrap_scan;
   logic             adj_entry;

   function automatic state_t flip(input state_t s);
      return (s == RUN) ? PAUSED : RUN;
   endfunction

   assign wrap_1hz   = (state == RUN) && (cnt_1hz == TOP_1HZ);
   assign wrap_2hz   = (state == ADJ) && (cnt_2hz == TOP_2HZ);
   assign wrap_blink = (state == ADJ) && (cnt_blink == TOP_BLINK);
   assign wrap_scan  = (cnt_scan == TOP_SCAN);
   // The next state is ADJ exactly when adj is high, so entry is adj outside ADJ.
   assign adj_entry  = adj && (state != ADJ);
   assign mode       = state;

   // Mode state machine; pause requests during ADJ or an adj change land on the return state.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         ret_state <= RUN;
      end else begin
         case (state)
            RUN, PAUSED: begin
               if (adj) begin
                  state     <= ADJ;
                  ret_state <= pause_p ? flip(state) : state;
               end else if (pause_p) begin
                  state <= flip(state);
               end
            end
            ADJ: begin
               if (!adj) begin
                  state <= pause_p ? flip(ret_state) : ret_state;
               end else if (pause_p) begin
                  ret_state <= flip(ret_state);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Prescale counters; the 1Hz count freezes outside RUN so a resume continues mid-second.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_1hz   <= '0;
         cnt_2hz   <= '0;
         cnt_blink <= '0;
         cnt_scan  <= '0;
      end else begin
         cnt_scan <= wrap_scan ? '0 : cnt_scan + ONE;

         if (clear_p) begin
            cnt_1hz <= '0;
         end else if (state == RUN) begin
            cnt_1hz <= wrap_1hz ? '0 : cnt_1hz + ONE;
         end

         if (adj_entry) begin
            cnt_2hz   <= '0;
            cnt_blink <= '0;
         end else if (state == ADJ) begin
            cnt_2hz   <= wrap_2hz ? '0 : cnt_2hz + ONE;
            cnt_blink <= wrap_blink ? '0 : cnt_blink + ONE;
         end
      end
   end

   // Registered strobes and display controls; clear_p pre-empts any increment.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         inc_sec     <= 1'b0;
         inc_min_adj <= 1'b0;
         inc_sec_adj <= 1'b0;
         clear_cnt   <= 1'b0;
         scan_tick   <= 1'b0;
         field_sel   <= 1'b0;
         blink_on    <= 1'b1;
      end else begin
         inc_sec     <= wrap_1hz && !clear_p;
         inc_min_adj <= wrap_2hz && !clear_p && !field_sel;
         inc_sec_adj <= wrap_2hz && !clear_p && field_sel;
         clear_cnt   <= clear_p;
         scan_tick   <= wrap_scan;
         field_sel   <= sel;
         if (!adj || adj_entry) begin
            blink_on <= 1'b1;
         end else if (wrap_blink) begin
            blink_on <= ~blink_on;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Bench for stopwatch_tick_ctrl: directed mode scenarios plus random pulses,
// compared every cycle against a tick-count reference model.
module tb_stopwatch_tick_ctrl;

   localparam int DIV_1HZ   = 8;
   localparam int DIV_2HZ   = 4;
   localparam int DIV_BLINK = 2;
   localparam int DIV_SCAN  = 3;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       pause_p;
   logic       clear_p;
   logic       adj;
   logic       sel;
   logic       inc_sec;
   logic       inc_min_adj;
   logic       inc_sec_adj;
   logic       clear_cnt;
   logic       blink_on;
   logic       field_sel;
   logic       scan_tick;
   logic [1:0] mode;

   stopwatch_tick_ctrl #(
      .DIV_1HZ  (DIV_1HZ),
      .DIV_2HZ  (DIV_2HZ),
      .DIV_BLINK(DIV_BLINK),
      .DIV_SCAN (DIV_SCAN),
      .CNT_W    (4)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .pause_p    (pause_p),
      .clear_p    (clear_p),
      .adj        (adj),
      .sel        (sel),
      .inc_sec    (inc_sec),
      .inc_min_adj(inc_min_adj),
      .inc_sec_adj(inc_sec_adj),
      .clear_cnt  (clear_cnt),
      .blink_on   (blink_on),
      .field_sel  (field_sel),
      .scan_tick  (scan_tick),
      .mode       (mode)
   );

   always #100 clk_in = ~clk_in;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: modes as 0 RUN / 1 PAUSED / 2 ADJ, elapsed-tick tallies.
   int m_cycles, m_run_ticks, m_adj_ticks, m_mode, m_ret, m_fsel;
   int e_inc_sec, e_min_adj, e_sec_adj, e_clear, e_blink, e_fsel, e_scan, e_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic void model_reset();
      m_cycles = 0; m_run_ticks = 0; m_adj_ticks = 0;
      m_mode = 0; m_ret = 0; m_fsel = 0;
      e_inc_sec = 0; e_min_adj = 0; e_sec_adj = 0; e_clear = 0;
      e_blink = 1; e_fsel = 0; e_scan = 0; e_mode = 0;
   endfunction

   // Advance the model by one clock edge using the inputs present before the edge.
   function automatic void model_step();
      int nm, nr;
      m_cycles++;
      e_scan    = (m_cycles % DIV_SCAN == 0) ? 1 : 0;
      e_clear   = clear_p ? 1 : 0;
      e_inc_sec = 0; e_min_adj = 0; e_sec_adj = 0;
      if (m_mode == 0) begin
         m_run_ticks++;
         if (m_run_ticks % DIV_1HZ == 0 && !clear_p) e_inc_sec = 1;
      end
      if (clear_p) m_run_ticks = 0;
      if (m_mode == 2) begin
         m_adj_ticks++;
         if (m_adj_ticks % DIV_2HZ == 0 && !clear_p) begin
            if (m_fsel != 0) e_sec_adj = 1;
            else             e_min_adj = 1;
         end
      end
      nm = m_mode; nr = m_ret;
      if (m_mode != 2 && adj) begin
         nm = 2;
         nr = pause_p ? 1 - m_mode : m_mode;
         m_adj_ticks = 0;
      end else if (m_mode == 2 && !adj) begin
         nm = pause_p ? 1 - m_ret : m_ret;
      end else if (pause_p) begin
         if (m_mode == 2) nr = 1 - m_ret;
         else             nm = 1 - m_mode;
      end
      e_blink = (nm != 2) ? 1 : (((m_adj_ticks / DIV_BLINK) % 2 == 0) ? 1 : 0);
      m_fsel  = sel ? 1 : 0;
      e_fsel  = m_fsel;
      m_mode  = nm;
      m_ret   = nr;
      e_mode  = nm;
   endfunction

   task automatic check_all();
      chk("mode",        32'(mode),        32'(e_mode));
      chk("inc_sec",     32'(inc_sec),     32'(e_inc_sec));
      chk("inc_min_adj", 32'(inc_min_adj), 32'(e_min_adj));
      chk("inc_sec_adj", 32'(inc_sec_adj), 32'(e_sec_adj));
      chk("clear_cnt",   32'(clear_cnt),   32'(e_clear));
      chk("blink_on",    32'(blink_on),    32'(e_blink));
      chk("field_sel",   32'(field_sel),   32'(e_fsel));
      chk("scan_tick",   32'(scan_tick),   32'(e_scan));
      chk("one_strobe",  32'((32'(inc_sec) + 32'(inc_min_adj) + 32'(inc_sec_adj)
                              + 32'(clear_cnt)) <= 1), 32'(1));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_mode"},    32'(mode),      32'(0));
      chk({tag, "_blink"},   32'(blink_on),  32'(1));
      chk({tag, "_fsel"},    32'(field_sel), 32'(0));
      chk({tag, "_strobes"}, 32'({inc_sec, inc_min_adj, inc_sec_adj, clear_cnt, scan_tick}),
          32'(0));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk_in);
      #1;
      check_all();
   endtask

   task automatic pulse_pause();
      pause_p = 1'b1; cycle(); pause_p = 1'b0;
   endtask

   initial begin
      int first, cnt_a, cnt_b, cnt_c, guard;
      rst = 1'b1; pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0; sel = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_reset_values("por");
      @(negedge clk_in);
      rst = 1'b0;

      // Idle RUN: 1 s strobes every 8 cycles, scan every 3.
      first = 0; cnt_a = 0; cnt_b = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if (inc_sec && first == 0) first = i;
         if (inc_sec) cnt_a++;
         if (scan_tick) cnt_b++;
      end
      chk("first_inc_sec", 32'(first), 32'(8));
      chk("inc_sec_count", 32'(cnt_a), 32'(5));
      chk("scan_count",    32'(cnt_b), 32'(13));

      // Pause and resume.
      repeat (5) cycle();
      pulse_pause();
      cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (inc_sec) cnt_a++;
      end
      chk("paused_no_inc", 32'(cnt_a), 32'(0));
      pulse_pause();
      repeat (12) cycle();

      // Adjust seconds then minutes.
      adj = 1'b1; sel = 1'b1;
      cycle();
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (inc_sec_adj) cnt_a++;
      end
      sel = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (inc_min_adj) cnt_b++;
         if (inc_sec_adj || inc_sec) cnt_c++;
      end
      chk("adj_sec_count", 32'(cnt_a), 32'(4));
      chk("adj_min_count", 32'(cnt_b), 32'(2));
      chk("adj_other",     32'(cnt_c), 32'(0));
      adj = 1'b0;
      repeat (3) cycle();

      // ADJ entered from PAUSED, pause inside ADJ returns to RUN; re-entry restarts.
      pulse_pause();
      adj = 1'b1;
      repeat (5) cycle();
      pulse_pause();
      repeat (3) cycle();
      adj = 1'b0;
      cycle();
      chk("return_run", 32'(mode), 32'(0));
      repeat (3) cycle();
      adj = 1'b1;
      repeat (7) cycle();
      // adj rise and pause together: return state becomes PAUSED.
      adj = 1'b0;
      cycle();
      adj = 1'b1; pause_p = 1'b1;
      cycle();
      pause_p = 1'b0;
      repeat (3) cycle();
      adj = 1'b0;
      cycle();
      chk("return_paused", 32'(mode), 32'(1));
      pulse_pause();

      // Clear on a 1 Hz wrap edge.
      guard = 0;
      while (!(m_mode == 0 && (m_run_ticks % DIV_1HZ) == DIV_1HZ - 1) && guard < 20) begin
         cycle();
         guard++;
      end
      chk("clear_align_bound", 32'(guard < 20), 32'(1));
      clear_p = 1'b1;
      cycle();
      clear_p = 1'b0;
      chk("clear_no_inc", 32'(inc_sec), 32'(0));
      first = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         if (inc_sec && first == 0) first = i;
      end
      chk("inc_after_clear", 32'(first), 32'(8));

      // Random pulses and mode changes.
      for (int i = 0; i < 500; i++) begin
         pause_p = ($urandom_range(15) == 0);
         clear_p = ($urandom_range(15) == 0);
         if ($urandom_range(23) == 0) adj = ~adj;
         if ($urandom_range(7) == 0)  sel = ~sel;
         cycle();
      end
      pause_p = 1'b0; clear_p = 1'b0;

      // Async reset mid-ADJ while the field is blanked.
      adj = 1'b1;
      guard = 0;
      while (!(m_mode == 2 && e_blink == 0) && guard < 20) begin
         cycle();
         guard++;
      end
      chk("blank_reach_bound", 32'(guard < 20), 32'(1));
      sel = 1'b1;
      #50;
      rst = 1'b1;
      #1;
      check_reset_values("async");
      model_reset();
      adj = 1'b0; sel = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         if (inc_sec && first == 0) first = i;
      end
      chk("first_inc_after_rst", 32'(first), 32'(8));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
